// File: rtl/pip_hazard_ctrl_pkg.sv
// rtl/pip_hazard_ctrl_pkg.sv - shared constants and types for the lacpu hazard controller
package pip_pkg;

  localparam int STAGES_DEF = 6;

  // Stage indices for the default six-stage lacpu pipeline; fetch is stage 0.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_LSU = 4;
  localparam int STG_WB  = STAGES_DEF - 1;

  localparam logic [STAGES_DEF-1:0] STALL_NONE = '0;
  localparam logic [STAGES_DEF-1:0] STALL_ALL  = '1;

  // Which rule owns the stall/flush outputs this cycle, highest priority last.
  typedef enum logic [1:0] {
    HZ_IDLE   = 2'd0,
    HZ_STAGE  = 2'd1,
    HZ_FLUSH  = 2'd2,
    HZ_GLOBAL = 2'd3
  } hz_cause_e;

  function automatic int stg_wb(input int stages);
    return stages - 1;
  endfunction

  // Counter width able to hold the value n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pip_hazard_ctrl_if.sv
// rtl/pip_hazard_ctrl_if.sv - hazard request/response bundle between pipeline and controller
interface pip_hazard_ctrl_if
  import pip_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int CNT_W  = 32
);
  logic [STAGES-1:0] stallreq;
  logic              stallreq_glb;
  logic              except_en;
  logic              flush;
  logic [STAGES-1:0] stall;
  logic              stall_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output stallreq, stallreq_glb, except_en,
    input  flush, stall, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq, stallreq_glb, except_en,
    output flush, stall, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pip_hazard_ctrl_stall_mask_enc.sv
// rtl/pip_hazard_ctrl_stall_mask_enc.sv - highest-set-bit to thermometer stall mask encoder
// A stage that cannot advance also freezes every earlier stage behind it.
module stall_mask_enc
  import pip_pkg::*;
#(
  parameter int STAGES = STAGES_DEF
) (
  input  logic [STAGES-1:0] req_i,
  output logic [STAGES-1:0] mask_o
);

  logic seen;

  always_comb begin
    mask_o = '0;
    seen   = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      seen      = seen | req_i[k];
      mask_o[k] = seen;
    end
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// rtl/pip_hazard_ctrl.sv - pipeline stall/flush controller with pending exceptions and stall watchdog
// stall/flush are combinational so they meet the same edge the stage registers sample on.
module pip_hazard_ctrl
  import pip_pkg::*;
#(
  parameter int STAGES    = STAGES_DEF,
  parameter int FLUSH_LEN = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 32
) (
  input logic               clk,
  input logic               resetn,
  pip_hazard_ctrl_if.slave  hz
);

  localparam int FC_W = cnt_w(FLUSH_LEN);
  localparam int TC_W = cnt_w(TIMEOUT);

  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_LEN - 1);
  localparam logic [TC_W-1:0] TO_MAX       = TC_W'(TIMEOUT);
  localparam logic [TC_W-1:0] TO_HIT       = TC_W'(TIMEOUT - 1);

  logic              except_pend_q, except_pend_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [TC_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  logic              glb;
  logic              flush_fire;
  logic              flush_active;
  logic [STAGES-1:0] stage_mask;
  logic [STAGES-1:0] stall_vec;
  logic              flush_sig;
  logic              stall_any;
  hz_cause_e         cause;

  assign glb = hz.stallreq_glb;

  stall_mask_enc #(
    .STAGES (STAGES)
  ) u_mask_enc (
    .req_i  (hz.stallreq),
    .mask_o (stage_mask)
  );

  assign flush_fire   = ~glb & (hz.except_en | except_pend_q);
  assign flush_active = ~glb & (flush_fire | (flush_cnt_q != '0));

  always_comb begin
    if (!resetn) begin
      cause = HZ_IDLE;
    end else if (glb) begin
      cause = HZ_GLOBAL;
    end else if (flush_active) begin
      cause = HZ_FLUSH;
    end else if (|hz.stallreq) begin
      cause = HZ_STAGE;
    end else begin
      cause = HZ_IDLE;
    end
  end

  always_comb begin
    stall_vec = '0;
    flush_sig = 1'b0;
    unique case (cause)
      HZ_GLOBAL: stall_vec = '1;
      HZ_FLUSH:  flush_sig = 1'b1;
      HZ_STAGE:  stall_vec = stage_mask;
      HZ_IDLE:   stall_vec = '0;
    endcase
  end

  assign stall_any = |stall_vec;

  // An exception seen under a global stall is parked until the bus lets go.
  always_comb begin
    except_pend_d = except_pend_q;
    if (glb && hz.except_en) begin
      except_pend_d = 1'b1;
    end else if (flush_fire) begin
      except_pend_d = 1'b0;
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush_fire) begin
      flush_cnt_d = FLUSH_RELOAD;
    end else if (!glb && (flush_cnt_q != '0)) begin
      flush_cnt_d = flush_cnt_q - FC_W'(1);
    end
  end

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = 1'b0;
    cycles_d  = cycles_q;
    if (stall_any) begin
      to_cnt_d  = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TC_W'(1);
      timeout_d = timeout_q | (to_cnt_q >= TO_HIT);
      if (~&cycles_q) begin
        cycles_d = cycles_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      except_pend_q <= 1'b0;
      flush_cnt_q   <= '0;
      to_cnt_q      <= '0;
      timeout_q     <= 1'b0;
      cycles_q      <= '0;
    end else begin
      except_pend_q <= except_pend_d;
      flush_cnt_q   <= flush_cnt_d;
      to_cnt_q      <= to_cnt_d;
      timeout_q     <= timeout_d;
      cycles_q      <= cycles_d;
    end
  end

  assign hz.stall         = stall_vec;
  assign hz.flush         = flush_sig;
  assign hz.stall_timeout = timeout_q;
  assign hz.stall_cycles  = cycles_q;

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// tb/tb_pip_hazard_ctrl.sv - directed self-checking bench for pip_hazard_ctrl
// Instance a: FLUSH_LEN=3, CNT_W=32. Instance b: FLUSH_LEN=1, CNT_W=4. Both TIMEOUT=8.
module tb_pip_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] stallreq;
  logic       glb;
  logic       exc;

  int n_chk = 0;
  int n_err = 0;

  pip_hazard_ctrl_if #(.STAGES(6), .CNT_W(32)) ha ();
  pip_hazard_ctrl_if #(.STAGES(6), .CNT_W(4))  hb ();

  assign ha.stallreq     = stallreq;
  assign ha.stallreq_glb = glb;
  assign ha.except_en    = exc;
  assign hb.stallreq     = stallreq;
  assign hb.stallreq_glb = glb;
  assign hb.except_en    = exc;

  pip_hazard_ctrl #(.STAGES(6), .FLUSH_LEN(3), .TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .hz     (ha)
  );

  pip_hazard_ctrl #(.STAGES(6), .FLUSH_LEN(1), .TIMEOUT(8), .CNT_W(4)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    resetn = 1'b0; stallreq = '0; glb = 1'b0; exc = 1'b0;
    step(); step();
    #1;
    chk("rst_flush", 32'(ha.flush), 0);
    chk("rst_stall", 32'(ha.stall), 0);
    chk("rst_timeout", 32'(ha.stall_timeout), 0);
    chk("rst_cycles", ha.stall_cycles, 0);
    resetn = 1'b1;
    step();

    // thermometer masks from the highest requesting stage
    stallreq = 6'b000100; #1;
    chk("therm_000100", 32'(ha.stall), 32'h07);
    chk("therm_flush", 32'(ha.flush), 0);
    step();
    stallreq = 6'b010100; #1;
    chk("therm_010100", 32'(ha.stall), 32'h1f);
    step();
    stallreq = 6'b100000; #1;
    chk("therm_100000", 32'(ha.stall), 32'h3f);
    step();
    stallreq = 6'b000000; #1;
    chk("therm_none", 32'(ha.stall), 0);
    chk("cycles_after_therm", ha.stall_cycles, 3);
    step();

    // exception under global stall goes pending, flushes on the drop cycle
    glb = 1'b1; stallreq = 6'b000001; exc = 1'b1; #1;
    chk("glb_stall", 32'(ha.stall), 32'h3f);
    chk("glb_exc_flush", 32'(ha.flush), 0);
    step();
    exc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("glb_hold_flush", 32'(hb.flush), 0);
      step();
    end
    glb = 1'b0; stallreq = '0; #1;
    chk("drop_flush_a", 32'(ha.flush), 1);
    chk("drop_flush_b", 32'(hb.flush), 1);
    chk("drop_stall", 32'(ha.stall), 0);
    step(); #1;
    chk("drop1_flush_a", 32'(ha.flush), 1);
    chk("drop1_flush_b", 32'(hb.flush), 0);
    step(); #1;
    chk("drop2_flush_a", 32'(ha.flush), 1);
    step(); #1;
    chk("drop3_flush_a", 32'(ha.flush), 0);
    chk("cycles_after_glb_b", 32'(hb.stall_cycles), 9);
    step();

    // FLUSH_LEN=3 window
    exc = 1'b1; #1;
    chk("win_c10", 32'(ha.flush), 1);
    step();
    exc = 1'b0; #1;
    chk("win_c11", 32'(ha.flush), 1);
    step(); #1;
    chk("win_c12", 32'(ha.flush), 1);
    step(); #1;
    chk("win_c13", 32'(ha.flush), 0);
    step();

    // retrigger inside the window restarts it
    exc = 1'b1; #1;
    chk("re_c10", 32'(ha.flush), 1);
    step(); #1;
    chk("re_c11", 32'(ha.flush), 1);
    step();
    exc = 1'b0; #1;
    chk("re_c12", 32'(ha.flush), 1);
    step(); #1;
    chk("re_c13", 32'(ha.flush), 1);
    step(); #1;
    chk("re_c14", 32'(ha.flush), 0);
    step();

    // global stall inside the window holds it
    exc = 1'b1; #1;
    chk("hold_c10", 32'(ha.flush), 1);
    step();
    exc = 1'b0; glb = 1'b1; #1;
    chk("hold_c11_flush", 32'(ha.flush), 0);
    chk("hold_c11_stall", 32'(ha.stall), 32'h3f);
    step();
    glb = 1'b0; #1;
    chk("hold_c12", 32'(ha.flush), 1);
    chk("hold_c12_stall", 32'(ha.stall), 0);
    step(); #1;
    chk("hold_c13", 32'(ha.flush), 1);
    step(); #1;
    chk("hold_c14", 32'(ha.flush), 0);
    step();

    // watchdog and perf counter from a clean state
    resetn = 1'b0; step(); resetn = 1'b1; step();
    for (int i = 1; i <= 10; i++) begin
      stallreq = 6'b000100; #1;
      chk("wd_timeout", 32'(ha.stall_timeout), 32'(i >= 9));
      step();
    end
    stallreq = '0; #1;
    chk("wd_drop_timeout", 32'(ha.stall_timeout), 1);
    chk("wd_cycles_a", ha.stall_cycles, 10);
    chk("wd_cycles_b", 32'(hb.stall_cycles), 10);
    step(); #1;
    chk("wd_clear_timeout", 32'(ha.stall_timeout), 0);
    step();
    for (int i = 0; i < 8; i++) begin
      stallreq = 6'b000100;
      step();
    end
    stallreq = '0; #1;
    chk("sat_cycles_a", ha.stall_cycles, 18);
    chk("sat_cycles_b", 32'(hb.stall_cycles), 15);
    step();

    // reset with an open window and a pending exception
    exc = 1'b1; #1;
    chk("pre_rst_flush", 32'(ha.flush), 1);
    step();
    glb = 1'b1; #1;
    chk("pre_rst_pend_flush", 32'(ha.flush), 0);
    step();
    exc = 1'b0; #1;
    resetn = 1'b0; #1;
    chk("mid_rst_flush", 32'(ha.flush), 0);
    chk("mid_rst_stall", 32'(ha.stall), 0);
    chk("mid_rst_cycles", ha.stall_cycles, 0);
    step(); step();
    glb = 1'b0; resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_flush", 32'(ha.flush), 0);
      chk("post_rst_stall", 32'(ha.stall), 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
